// File: rtl/hazard_ctrl.sv
// Purpose : pipeline hazard/flush controller; stall and bubble controls for PC/FD/DE/EM/MW.
// Latency : outputs combinational from state, mc_cnt and inputs; next-state registered.
// Backpr. : memory wait freezes PC..EM and bubbles MW; multicycle EX freezes PC..DE.
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   id_rs1/id_rs2, id_uses_rs*    ID-stage source registers and their use flags
//   ex_rd, ex_is_load             EX-stage destination register and load flag
//   ex_branch_taken, ex_mc_start  EX-stage branch resolution / multicycle start
//   mem_req, mem_ready            data-memory request and completion
//   *_stall, *_bubble             register hold / register clear (bubble wins)
//   mc_done                       final EX cycle of a multicycle op
// Optional: define HAZARD_CTRL_PERF_EN for perf_stall_cycles / perf_flushes outputs.
module hazard_ctrl #(
    parameter int MC_LATENCY = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] id_rs1,
    input  logic [4:0] id_rs2,
    input  logic       id_uses_rs1,
    input  logic       id_uses_rs2,
    input  logic [4:0] ex_rd,
    input  logic       ex_is_load,
    input  logic       ex_branch_taken,
    input  logic       ex_mc_start,
    input  logic       mem_req,
    input  logic       mem_ready,
    output logic       pc_stall,
    output logic       fd_stall,
    output logic       de_stall,
    output logic       em_stall,
    output logic       fd_bubble,
    output logic       de_bubble,
    output logic       em_bubble,
    output logic       mw_bubble,
    output logic       mc_done
`ifdef HAZARD_CTRL_PERF_EN
    ,
    output logic [31:0] perf_stall_cycles,
    output logic [15:0] perf_flushes
`endif
);

    localparam int CW = $clog2(MC_LATENCY);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MC_BUSY  = 2'd1,
        MEM_WAIT = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   mc_cnt_q, mc_cnt_d;
    logic            memwait;
    logic            lu;
    logic            flush_acc;

    assign memwait = mem_req & ~mem_ready;
    assign lu = ex_is_load & (ex_rd != 5'd0) &
                ((id_uses_rs1 & (id_rs1 == ex_rd)) | (id_uses_rs2 & (id_rs2 == ex_rd)));

    always_comb begin
        state_d   = state_q;
        mc_cnt_d  = mc_cnt_q;
        pc_stall  = 1'b0;
        fd_stall  = 1'b0;
        de_stall  = 1'b0;
        em_stall  = 1'b0;
        fd_bubble = 1'b0;
        de_bubble = 1'b0;
        em_bubble = 1'b0;
        mw_bubble = 1'b0;
        mc_done   = 1'b0;
        flush_acc = 1'b0;
        if (rst) begin
            fd_bubble = 1'b1;
            de_bubble = 1'b1;
            em_bubble = 1'b1;
            mw_bubble = 1'b1;
        end else begin
            case (state_q)
                RUN: begin
                    if (memwait) begin
                        pc_stall  = 1'b1;
                        fd_stall  = 1'b1;
                        de_stall  = 1'b1;
                        em_stall  = 1'b1;
                        mw_bubble = 1'b1;
                        state_d   = MEM_WAIT;
                    end else if (ex_branch_taken) begin
                        fd_bubble = 1'b1;
                        de_bubble = 1'b1;
                        flush_acc = 1'b1;
                    end else if (ex_mc_start) begin
                        pc_stall  = 1'b1;
                        fd_stall  = 1'b1;
                        de_stall  = 1'b1;
                        em_bubble = 1'b1;
                        // Start cycle and done cycle bracket the busy count.
                        mc_cnt_d  = CW'(MC_LATENCY - 2);
                        state_d   = MC_BUSY;
                    end else if (lu) begin
                        pc_stall  = 1'b1;
                        fd_stall  = 1'b1;
                        de_bubble = 1'b1;
                    end
                end
                MC_BUSY: begin
                    if (mc_cnt_q != '0) begin
                        pc_stall  = 1'b1;
                        fd_stall  = 1'b1;
                        de_stall  = 1'b1;
                        em_bubble = 1'b1;
                        mc_cnt_d  = mc_cnt_q - 1'b1;
                    end else begin
                        mc_done = 1'b1;
                        state_d = RUN;
                    end
                end
                MEM_WAIT: begin
                    if (!mem_ready) begin
                        pc_stall  = 1'b1;
                        fd_stall  = 1'b1;
                        de_stall  = 1'b1;
                        em_stall  = 1'b1;
                        mw_bubble = 1'b1;
                    end else begin
                        // Pipeline advances at this edge; hazards are judged next cycle.
                        state_d = RUN;
                    end
                end
                default: state_d = RUN;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= RUN;
            mc_cnt_q <= '0;
        end else begin
            state_q  <= state_d;
            mc_cnt_q <= mc_cnt_d;
        end
    end

`ifdef HAZARD_CTRL_PERF_EN
    logic [31:0] perf_stall_q, perf_stall_d;
    logic [15:0] perf_flushes_q, perf_flushes_d;

    // Saturating counters: stick at all-ones instead of wrapping.
    always_comb begin
        perf_stall_d   = perf_stall_q;
        perf_flushes_d = perf_flushes_q;
        if (pc_stall && (perf_stall_q != '1))
            perf_stall_d = perf_stall_q + 32'd1;
        if (flush_acc && (perf_flushes_q != '1))
            perf_flushes_d = perf_flushes_q + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_stall_q   <= '0;
            perf_flushes_q <= '0;
        end else begin
            perf_stall_q   <= perf_stall_d;
            perf_flushes_q <= perf_flushes_d;
        end
    end

    assign perf_stall_cycles = perf_stall_q;
    assign perf_flushes      = perf_flushes_q;
`endif

endmodule
